// File: rtl/decoder_pipe_hs.sv
// Select-token decoder (one-hot or thermometer) behind a valid/ready input, with a small output FIFO
// and a saturating delivered-token counter. Optional parity check: define DECODER_PIPE_PARITY_EN.
module decoder_pipe_hs #(
    parameter int SEL_W = 3,
    parameter int MODE  = 0,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8,
    localparam int DEC_W = 1 << SEL_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_en,
`ifdef DECODER_PIPE_PARITY_EN
    input  logic             in_par,
    output logic             par_err,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DEC_W-1:0] out_dec,
    output logic [SEL_W-1:0] out_sel,
    output logic [CNT_W-1:0] tok_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam int ENT_W = SEL_W + DEC_W;

    logic [DEPTH-1:0][ENT_W-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]            occ_q, occ_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic [DEC_W-1:0]            dec_w;
    logic                        push_hs, enq, pop, par_ok;

    // Decode lanes: each bit compares its own index against the select.
    for (genvar i = 0; i < DEC_W; i++) begin : g_dec
        localparam logic [SEL_W:0] IDX = (SEL_W + 1)'(i);
        if (MODE == 0) begin : g_onehot
            assign dec_w[i] = in_en && (IDX == {1'b0, in_sel});
        end else begin : g_therm
            assign dec_w[i] = in_en && (IDX <= {1'b0, in_sel});
        end
    end

`ifdef DECODER_PIPE_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_ok  = ^{in_sel, in_par};
    assign par_err = par_err_q;
`else
    assign par_ok  = 1'b1;
`endif

    assign in_ready  = (occ_q != OCC_W'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign push_hs   = in_valid && in_ready;
    assign enq       = push_hs && par_ok;
    assign pop       = out_valid && out_ready;
    assign {out_sel, out_dec} = out_valid ? mem_q[rd_ptr_q] : '0;
    assign tok_cnt   = cnt_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (enq) begin
            mem_d[wr_ptr_q] = {in_sel, dec_w};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
        end
        occ_d = occ_q + OCC_W'(enq) - OCC_W'(pop);
`ifdef DECODER_PIPE_PARITY_EN
        par_err_d = par_err_q || (push_hs && !par_ok);
`endif
    end

    // Storage needs no reset: the output mux forces zeros while empty.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            cnt_q     <= '0;
`ifdef DECODER_PIPE_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            cnt_q     <= cnt_d;
`ifdef DECODER_PIPE_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end
endmodule

// File: tb/tb_decoder_pipe_hs.sv
// Scoreboard bench: a one-hot instance and a thermometer instance (CNT_W=2) share the same stimulus.
module tb_decoder_pipe_hs;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0, in_en = 1'b0, out_ready = 1'b1;
    logic [2:0] in_sel = '0;
    logic       a_in_ready, a_out_valid, b_in_ready, b_out_valid;
    logic [7:0] a_dec, b_dec;
    logic [2:0] a_sel, b_sel;
    logic [7:0] a_cnt;
    logic [1:0] b_cnt;
`ifdef DECODER_PIPE_PARITY_EN
    logic       in_par = 1'b0;
    logic       a_perr, b_perr;
`endif
    logic [10:0] qa[$], qb[$];
    int n_cmp = 0, n_bad = 0;

    always #5 clock = ~clock;

    decoder_pipe_hs #(.SEL_W(3), .MODE(0), .DEPTH(2), .CNT_W(8)) dut_a (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_sel(in_sel), .in_en(in_en),
`ifdef DECODER_PIPE_PARITY_EN
        .in_par(in_par), .par_err(a_perr),
`endif
        .out_valid(a_out_valid), .out_ready(out_ready), .out_dec(a_dec),
        .out_sel(a_sel), .tok_cnt(a_cnt));

    decoder_pipe_hs #(.SEL_W(3), .MODE(1), .DEPTH(2), .CNT_W(2)) dut_b (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_sel(in_sel), .in_en(in_en),
`ifdef DECODER_PIPE_PARITY_EN
        .in_par(in_par), .par_err(b_perr),
`endif
        .out_valid(b_out_valid), .out_ready(out_ready), .out_dec(b_dec),
        .out_sel(b_sel), .tok_cnt(b_cnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every head consumed must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset) begin
            if (a_out_valid && out_ready) begin
                if (qa.size() == 0) chk("a_extra_token", {21'd0, a_sel, a_dec}, 32'hFFFF);
                else chk("a_head", {21'd0, a_sel, a_dec}, {21'd0, qa.pop_front()});
            end else if (!a_out_valid) chk("a_idle_zero", {21'd0, a_sel, a_dec}, 0);
            if (b_out_valid && out_ready) begin
                if (qb.size() == 0) chk("b_extra_token", {21'd0, b_sel, b_dec}, 32'hFFFF);
                else chk("b_head", {21'd0, b_sel, b_dec}, {21'd0, qb.pop_front()});
            end else if (!b_out_valid) chk("b_idle_zero", {21'd0, b_sel, b_dec}, 0);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [2:0] sel, input logic en, input logic bad,
                        input logic [7:0] ea, input logic [7:0] eb);
        logic hs = 1'b0;
        int   n = 0;
        in_valid = 1'b1; in_sel = sel; in_en = en;
`ifdef DECODER_PIPE_PARITY_EN
        in_par = bad ? ^sel : ~^sel;
`endif
        while (!hs && n < 50) begin
            @(negedge clock);
            hs = a_in_ready && b_in_ready;
            if (hs && !bad) begin
                qa.push_back({sel, ea});
                qb.push_back({sel, eb});
            end
            @(posedge clock); #1;
            n++;
        end
        if (!hs) chk("push_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    logic [7:0] sat_a [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10};
    logic [7:0] sat_b [5] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F};

    initial begin
        cyc(2);
        reset = 1'b0;
        cyc(1);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_dec", a_dec, 0);
        chk("rst_out_sel", a_sel, 0);
        chk("rst_tok_cnt", a_cnt, 0);
        chk("rst_tok_cnt_b", b_cnt, 0);

        // Single token, one-cycle latency into an empty FIFO.
        push(3'd5, 1'b1, 1'b0, 8'h20, 8'h3F);
        chk("lat_valid", a_out_valid, 1);
        chk("lat_dec", a_dec, 8'h20);
        chk("lat_sel", a_sel, 5);
        cyc(2);
        chk("tok_after_one", a_cnt, 1);

        push(3'd0, 1'b1, 1'b0, 8'h01, 8'h01);
        push(3'd5, 1'b0, 1'b0, 8'h00, 8'h00);
        push(3'd7, 1'b1, 1'b0, 8'h80, 8'hFF);
        cyc(3);
        chk("tok_a_4", a_cnt, 4);
        chk("tok_b_sat", b_cnt, 3);

        // Fill with consumer stalled; third token must be refused.
        out_ready = 1'b0;
        push(3'd1, 1'b1, 1'b0, 8'h02, 8'h03);
        push(3'd2, 1'b1, 1'b0, 8'h04, 8'h07);
        chk("full_in_ready", a_in_ready, 0);
        in_valid = 1'b1; in_sel = 3'd6; in_en = 1'b1;
`ifdef DECODER_PIPE_PARITY_EN
        in_par = ~^in_sel;
`endif
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("full_stall_ready", a_in_ready, 0);
            chk("hold_dec_a", a_dec, 8'h02);
            chk("hold_dec_b", b_dec, 8'h03);
        end
        @(posedge clock); #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc(4);

        // Simultaneous push and pop with one entry held.
        out_ready = 1'b0;
        push(3'd4, 1'b1, 1'b0, 8'h10, 8'h1F);
        out_ready = 1'b1;
        push(3'd3, 1'b1, 1'b0, 8'h08, 8'h0F);
        chk("pp_out_valid", a_out_valid, 1);
        chk("pp_in_ready", a_in_ready, 1);
        chk("pp_head", a_dec, 8'h08);
        cyc(3);
        chk("tok_a_8", a_cnt, 8);
        chk("tok_b_hold_sat", b_cnt, 3);

        // Reset with the FIFO full discards everything.
        out_ready = 1'b0;
        push(3'd1, 1'b1, 1'b0, 8'h02, 8'h03);
        push(3'd2, 1'b1, 1'b0, 8'h04, 8'h07);
        reset = 1'b1; out_ready = 1'b1;
        qa.delete(); qb.delete();
        cyc(1);
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_tok_a", a_cnt, 0);
        chk("mid_rst_tok_b", b_cnt, 0);
        reset = 1'b0;
        cyc(1);
        chk("post_rst_ready", a_in_ready, 1);
        chk("post_rst_valid", b_out_valid, 0);

        for (int k = 0; k < 5; k++) push(3'(k), 1'b1, 1'b0, sat_a[k], sat_b[k]);
        cyc(3);
        chk("sat_tok_a", a_cnt, 5);
        chk("sat_tok_b", b_cnt, 3);

`ifdef DECODER_PIPE_PARITY_EN
        chk("par_err_clear", a_perr, 0);
        push(3'b011, 1'b1, 1'b1, 8'h00, 8'h00);
        chk("bad_par_valid", a_out_valid, 0);
        chk("bad_par_err_a", a_perr, 1);
        chk("bad_par_err_b", b_perr, 1);
        push(3'b011, 1'b1, 1'b0, 8'h08, 8'h0F);
        cyc(3);
        chk("good_par_tok", a_cnt, 6);
        chk("par_err_sticky", a_perr, 1);
`endif

        for (int k = 0; k < 20 && (qa.size() != 0 || qb.size() != 0); k++) cyc(1);
        chk("drain_a", qa.size(), 0);
        chk("drain_b", qb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
